// File: rtl/prbs_burst_if.sv
// Command/status bundle between lab control logic and the PRBS burst controller.
// The master drives burst commands; the slave (controller) returns status and the bit stream.
interface prbs_burst_if #(
  parameter int LEN_W = 16
);
  logic             seed_load;
  logic [7:0]       seed;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             prbs;
  logic             prbs_valid;
  logic [7:0]       q;
  logic             seed_err;

  modport master (
    output seed_load, seed, start, len, abort,
    input  busy, done, aborted, prbs, prbs_valid, q, seed_err
  );

  modport slave (
    input  seed_load, seed, start, len, abort,
    output busy, done, aborted, prbs, prbs_valid, q, seed_err
  );
endinterface

// File: rtl/prbs_burst_ctrl.sv
// Burst controller around an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
// Seeds and guards the LFSR, emits len qualified bits per burst, then pulses done.
module prbs_burst_ctrl #(
  parameter logic [7:0] SEED  = 8'hFF,
  parameter int         LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  prbs_burst_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [7:0]       q, q_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic             abt, abt_nxt;
  logic             err, err_nxt;
  logic             vld_p0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= SEED;
      cnt   <= '0;
      abt   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
      abt   <= abt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = cnt;
    abt_nxt   = abt;
    err_nxt   = err;
    vld_p0    = 1'b0;
    case (state)
      IDLE: begin
        abt_nxt = 1'b0;
        // A zero seed would lock the LFSR up, so it is replaced and flagged.
        if (bus.seed_load) begin
          if (bus.seed == 8'h00) begin
            q_nxt   = SEED;
            err_nxt = 1'b1;
          end else begin
            q_nxt = bus.seed;
          end
        end
        if (bus.start) begin
          cnt_nxt   = bus.len;
          state_nxt = (bus.len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort wins over the last bit; the abort-cycle bit is withheld.
        if (bus.abort) begin
          abt_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          vld_p0  = 1'b1;
          q_nxt   = lfsr_step(q);
          cnt_nxt = cnt - LEN_W'(1);
          if (cnt == LEN_W'(1)) state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.aborted    = (state == DONE) && abt;
  assign bus.prbs       = q[7];
  assign bus.prbs_valid = vld_p0;
  assign bus.q          = q;
  assign bus.seed_err   = err;

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Bench for prbs_burst_ctrl: directed vector table, hand-written corner sequences,
// and randomized bursts checked against a burst-level reference model.
module tb_prbs_burst_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  prbs_burst_if #(.LEN_W(16)) bus ();

  prbs_burst_ctrl #(.SEED(8'hFF), .LEN_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        sl;
    logic [7:0]  sd;
    logic        st;
    logic [15:0] ln;
    logic        ab;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        prbs;
    logic        valid;
    logic [7:0]  q;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  int n_checks = 0;
  int n_err    = 0;

  int          nv, ones, t, done_t, n_exp, done_exp, ln, a;
  logic        got_done, ok, ab_seen, saw_done, do_seed, same;
  logic [7:0]  mq, sd;
  logic        merr;
  logic [2:0]  bits;
  logic [255:0] seen;

  function automatic logic [7:0] ref_step(input logic [7:0] v);
    // Taps of x^8+x^6+x^5+x^4 are state bits 7,5,4,3.
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  function automatic vec_t mk(input logic sl, input logic [7:0] sd_i, input logic st,
                              input logic [15:0] ln_i, input logic ab, input logic busy,
                              input logic done, input logic aborted, input logic prbs,
                              input logic valid, input logic [7:0] q);
    vec_t v;
    v.sl = sl; v.sd = sd_i; v.st = st; v.ln = ln_i; v.ab = ab;
    v.busy = busy; v.done = done; v.aborted = aborted;
    v.prbs = prbs; v.valid = valid; v.q = q;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.seed_load = 1'b0;
    bus.seed      = 8'h00;
    bus.start     = 1'b0;
    bus.len       = 16'd0;
    bus.abort     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs an already-started burst to completion, counting valid bits.
  task automatic run_to_done(input int bound);
    got_done = 1'b0;
    nv = 0;
    t = 0;
    while (!got_done && t < bound) begin
      @(negedge clk);
      if (bus.prbs_valid) nv++;
      if (bus.done) got_done = 1'b1;
      tick();
      t++;
    end
  endtask

  initial begin
    vt[0]  = mk(1, 8'h01, 0, 0, 0,  0, 0, 0, 1, 0, 8'hFF);
    vt[1]  = mk(0, 8'h00, 1, 8, 0,  0, 0, 0, 0, 0, 8'h01);
    vt[2]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 8'h01);
    vt[3]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 8'h02);
    vt[4]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 8'h04);
    vt[5]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 8'h08);
    vt[6]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 8'h11);
    vt[7]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 8'h23);
    vt[8]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 8'h47);
    vt[9]  = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 1, 1, 8'h8E);
    vt[10] = mk(0, 8'h00, 1, 5, 0,  1, 1, 0, 0, 0, 8'h1C);
    vt[11] = mk(0, 8'h00, 0, 0, 1,  0, 0, 0, 0, 0, 8'h1C);
    vt[12] = mk(0, 8'h00, 1, 0, 0,  0, 0, 0, 0, 0, 8'h1C);
    vt[13] = mk(0, 8'h00, 0, 0, 0,  1, 1, 0, 0, 0, 8'h1C);
    vt[14] = mk(1, 8'h80, 1, 2, 0,  0, 0, 0, 0, 0, 8'h1C);
    vt[15] = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 1, 1, 8'h80);
    vt[16] = mk(0, 8'h00, 0, 0, 0,  1, 0, 0, 0, 1, 8'h01);
    vt[17] = mk(0, 8'h00, 0, 0, 1,  1, 1, 0, 0, 0, 8'h02);
    vt[18] = mk(0, 8'h00, 0, 0, 0,  0, 0, 0, 0, 0, 8'h02);

    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", bus.busy, 0);
    check("rst.done", bus.done, 0);
    check("rst.aborted", bus.aborted, 0);
    check("rst.valid", bus.prbs_valid, 0);
    check("rst.q", bus.q, 8'hFF);
    check("rst.prbs", bus.prbs, 1);
    check("rst.seed_err", bus.seed_err, 0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      bus.seed_load = vt[i].sl;
      bus.seed      = vt[i].sd;
      bus.start     = vt[i].st;
      bus.len       = vt[i].ln;
      bus.abort     = vt[i].ab;
      @(negedge clk);
      check($sformatf("vec%0d.busy", i), bus.busy, vt[i].busy);
      check($sformatf("vec%0d.done", i), bus.done, vt[i].done);
      check($sformatf("vec%0d.aborted", i), bus.aborted, vt[i].aborted);
      check($sformatf("vec%0d.prbs", i), bus.prbs, vt[i].prbs);
      check($sformatf("vec%0d.valid", i), bus.prbs_valid, vt[i].valid);
      check($sformatf("vec%0d.q", i), bus.q, vt[i].q);
      tick();
    end
    drive_idle();

    // Full period from seed 01
    bus.seed_load = 1'b1; bus.seed = 8'h01; tick();
    bus.seed_load = 1'b0; bus.start = 1'b1; bus.len = 16'd255; tick();
    drive_idle();
    seen = '0; ones = 0; nv = 0; ok = 1'b1; t = 0; got_done = 1'b0;
    while (!got_done && t < 300) begin
      @(negedge clk);
      if (bus.prbs_valid) begin
        if (bus.q == 8'h00 || seen[bus.q]) ok = 1'b0;
        seen[bus.q] = 1'b1;
        ones += int'(bus.prbs);
        nv++;
      end
      if (bus.done) got_done = 1'b1;
      tick();
      t++;
    end
    check("p255.done", got_done, 1);
    check("p255.valid_cnt", nv, 255);
    check("p255.distinct", ok, 1);
    check("p255.ones", ones, 128);
    check("p255.q_wrap", bus.q, 8'h01);

    // Zero seed is substituted and sticky error raised
    bus.seed_load = 1'b1; bus.seed = 8'h00; tick();
    drive_idle();
    check("zseed.q", bus.q, 8'hFF);
    check("zseed.err", bus.seed_err, 1);
    bus.start = 1'b1; bus.len = 16'd3; tick();
    drive_idle();
    run_to_done(20);
    check("zseed.burst_done", got_done, 1);
    check("zseed.err_sticky", bus.seed_err, 1);

    // Abort on 10th RUN cycle, with ignored start/seed_load pulses during RUN
    bus.seed_load = 1'b1; bus.seed = 8'h01; tick();
    bus.seed_load = 1'b0; bus.start = 1'b1; bus.len = 16'd100; tick();
    drive_idle();
    mq = 8'h01; nv = 0; ok = 1'b1; t = 1; got_done = 1'b0; done_t = 0; ab_seen = 1'b0;
    while (!got_done && t < 120) begin
      bus.abort     = (t == 10);
      bus.start     = (t == 3);
      bus.len       = 16'd7;
      bus.seed_load = (t == 5);
      bus.seed      = 8'h55;
      @(negedge clk);
      if (t == 10) check("abort.cycle_valid", bus.prbs_valid, 0);
      if (bus.prbs_valid) begin
        if (bus.q !== mq || bus.prbs !== mq[7]) ok = 1'b0;
        mq = ref_step(mq);
        nv++;
      end
      if (bus.done) begin
        got_done = 1'b1;
        done_t = t;
        ab_seen = bus.aborted;
      end
      tick();
      t++;
    end
    drive_idle();
    check("abort.valid_cnt", nv, 9);
    check("abort.done_cycle", done_t, 11);
    check("abort.aborted", ab_seen, 1);
    check("abort.stream", ok, 1);
    check("abort.q_after", bus.q, mq);
    check("abort.idle", bus.busy, 0);

    // Reset mid-burst
    bus.start = 1'b1; bus.len = 16'd50; tick();
    drive_idle();
    repeat (20) tick();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.busy", bus.busy, 0);
    check("midrst.valid", bus.prbs_valid, 0);
    check("midrst.done", bus.done, 0);
    check("midrst.q", bus.q, 8'hFF);
    check("midrst.seed_err", bus.seed_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
      tick();
    end
    check("midrst.no_done", saw_done, 0);
    bus.start = 1'b1; bus.len = 16'd3; tick();
    drive_idle();
    bits = 3'b000; nv = 0; t = 0; got_done = 1'b0;
    while (!got_done && t < 20) begin
      @(negedge clk);
      if (bus.prbs_valid) begin
        if (nv < 3) bits[nv] = bus.prbs;
        nv++;
      end
      if (bus.done) got_done = 1'b1;
      tick();
      t++;
    end
    check("midrst.after_cnt", nv, 3);
    check("midrst.after_bits", bits, 3'b111);

    // Randomized bursts against a burst-level model
    merr = 1'b0;
    mq = 8'h00;
    for (int b = 0; b < 40; b++) begin
      do_seed = (b == 0) || ($urandom_range(0, 2) == 0);
      sd      = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      same    = 1'($urandom_range(0, 1));
      ln      = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
      a       = (ln > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, ln)) : 0;
      if (do_seed) begin
        if (sd == 8'h00) begin
          mq = 8'hFF;
          merr = 1'b1;
        end else begin
          mq = sd;
        end
        bus.seed_load = 1'b1;
        bus.seed = sd;
        if (!same) begin
          tick();
          bus.seed_load = 1'b0;
        end
      end
      bus.start = 1'b1;
      bus.len = 16'(ln);
      tick();
      drive_idle();
      n_exp    = (a != 0) ? a - 1 : ln;
      done_exp = (a != 0) ? a + 1 : ln + 1;
      nv = 0; ok = 1'b1; t = 1; got_done = 1'b0; done_t = 0; ab_seen = 1'b0;
      while (!got_done && t <= ln + 5) begin
        bus.abort     = (t == a);
        bus.start     = ($urandom_range(0, 3) == 0);
        bus.len       = 16'($urandom);
        bus.seed_load = ($urandom_range(0, 3) == 0);
        bus.seed      = 8'($urandom);
        @(negedge clk);
        if (bus.prbs_valid) begin
          if (bus.q !== mq || bus.prbs !== mq[7]) ok = 1'b0;
          mq = ref_step(mq);
          nv++;
        end
        if (bus.done) begin
          got_done = 1'b1;
          done_t = t;
          ab_seen = bus.aborted;
        end
        tick();
        t++;
      end
      drive_idle();
      check($sformatf("rnd%0d.valid_cnt", b), nv, n_exp);
      check($sformatf("rnd%0d.done_cycle", b), done_t, done_exp);
      check($sformatf("rnd%0d.aborted", b), ab_seen, (a != 0));
      check($sformatf("rnd%0d.stream", b), ok, 1);
      check($sformatf("rnd%0d.q_after", b), bus.q, mq);
      check($sformatf("rnd%0d.seed_err", b), bus.seed_err, merr);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
